fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of FIFO words and stream data.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 8: width of the burst-length request field.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rstn, input, 1: asynchronous active-low reset.
REQ-006 Port req_valid, input, 1: burst request offered.
REQ-007 Port req_len, input, LEN_WIDTH: number of words to deliver; sampled when req_valid && req_ready.
REQ-008 Port req_ready, output, 1: block can accept a request (high only in IDLE).
REQ-009 Port fifo_read_enable, output, 1: read strobe to the FIFO read port.
REQ-010 Port fifo_read_data, input, DATA_WIDTH: FIFO read data, valid exactly 1 cycle after a read_enable cycle.
REQ-011 Port fifo_empty, input, 1: FIFO empty flag.
REQ-012 Port m_valid, output, 1: stream beat available.
REQ-013 Port m_ready, input, 1: downstream accepts beat.
REQ-014 Port m_data, output, DATA_WIDTH: stream beat data.
REQ-015 Port m_last, output, 1: marks final beat of the current burst.
REQ-016 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, BURST, FLUSH.
REQ-018 IDLE: req_ready=1; on req_valid with req_len!=0, load issue_cnt=req_len and beat_cnt=req_len, go to BURST; req_len=0 is accepted and discarded, staying in IDLE.
REQ-019 BURST: issue reads while issue_cnt!=0; when the last read is issued, go to FLUSH.
REQ-020 FLUSH: no reads issued; go to IDLE in the cycle the final beat (m_last) is accepted.
REQ-021 Output buffer SHALL be a 2-entry FIFO-ordered skid buffer; credit = buffer occupancy + reads in flight (0 or 1), never exceeding 2.
REQ-022 fifo_read_enable SHALL be asserted only when state==BURST, issue_cnt!=0, fifo_empty==0, and credit<2 (counting the slot freed by a same-cycle m_valid&&m_ready pop).
REQ-023 fifo_read_enable SHALL never be asserted while fifo_empty==1 or in IDLE/FLUSH.
REQ-024 Each asserted read SHALL decrement issue_cnt by 1 and capture fifo_read_data into the buffer on the following clock edge.
REQ-025 m_valid SHALL equal (occupancy!=0); m_data SHALL be the oldest buffered word.
REQ-026 m_data and m_last SHALL hold stable while m_valid && !m_ready.
REQ-027 Each accepted beat (m_valid && m_ready) SHALL decrement beat_cnt; m_last SHALL be high iff m_valid and beat_cnt==1.
REQ-028 Simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-029 Sustained throughput SHALL be 1 beat/cycle when m_ready=1 and the FIFO stays non-empty; first beat m_valid appears 2 cycles after request acceptance.
REQ-030 Counters SHALL be LEN_WIDTH bits and never wrap below 0; a request of 2^LEN_WIDTH-1 words SHALL complete.
REQ-031 FIFO going empty mid-burst SHALL stall issuing without leaving BURST; issuing resumes the cycle fifo_empty deasserts.

Reset
REQ-032 On rstn low, state=IDLE, counters=0, buffer occupancy=0, in-flight flag cleared, immediately and asynchronously.
REQ-033 Reset values: req_ready=1, fifo_read_enable=0, m_valid=0, m_data=0, m_last=0, busy=0.
REQ-034 Reset mid-burst SHALL discard in-flight and buffered data; no beat emitted after rstn releases until a new request.

Verification
REQ-035 FIFO holds 0x11,0x22,0x33, m_ready=1, req_len=3 -> beats 0x11,0x22,0x33 on 3 consecutive cycles, m_last only on 0x33, then IDLE, req_ready=1.
REQ-036 req_len=4, m_ready low for 5 cycles after first m_valid -> at most 2 reads issued beyond beats accepted, m_data held at first word, no loss or duplication after release.
REQ-037 req_len=4, FIFO has 2 words, 2 more written 6 cycles later -> fifo_read_enable drops while fifo_empty=1, busy stays 1, all 4 beats delivered in order, m_last on 4th.
REQ-038 req_len=0 -> req_ready stays 1, busy stays 0, no fifo_read_enable, no m_valid.
REQ-039 rstn pulsed low after 2 of 6 beats accepted -> all outputs at reset values within the reset cycle, no further beats until a new request.
REQ-040 Random m_ready (50%), req_len=200 -> 200 beats in FIFO order, exactly one m_last, fifo_read_enable never high with fifo_empty=1.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader_if
//  Description : Bundles the request, FIFO read-port and output-stream signals
//                of fifo_stream_reader. The slave modport is the reader's view;
//                the master modport is the surrounding system's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  // Burst request channel
  logic                  req_valid;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  req_ready;
  // FIFO read port
  logic                  fifo_read_enable;
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic                  fifo_empty;
  // Output stream
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  // Status
  logic                  busy;

  modport slave (
    input  req_valid, req_len, fifo_read_data, fifo_empty, m_ready,
    output req_ready, fifo_read_enable, m_valid, m_data, m_last, busy
  );

  modport master (
    output req_valid, req_len, fifo_read_data, fifo_empty, m_ready,
    input  req_ready, fifo_read_enable, m_valid, m_data, m_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Accepts a burst-length request, reads that many words from a
//                FIFO read port (1-cycle read latency) and presents them as a
//                valid/ready stream with m_last on the final beat. A 2-entry
//                skid buffer with credit tracking sustains 1 beat/cycle while
//                absorbing downstream back-pressure without losing data.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  wire logic            clk,
  input  wire logic            rstn,
  fifo_stream_reader_if.slave  bus
);

  localparam logic [LEN_WIDTH-1:0] c_LEN_ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] c_LEN_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_issue_cnt;   // reads still to be issued
  logic [LEN_WIDTH-1:0]  r_beat_cnt;    // beats still to be accepted downstream
  logic                  r_inflight;    // a read was issued last cycle; data arrives now
  logic [1:0]            r_occ;         // skid buffer occupancy (0..2)
  logic [DATA_WIDTH-1:0] r_buf0;        // oldest entry, drives m_data
  logic [DATA_WIDTH-1:0] r_buf1;        // second entry

  logic                  w_pop;
  logic                  w_push;
  logic                  w_rd_en;
  logic                  w_req_take;
  logic                  w_last_pop;
  logic [1:0]            w_credit_after_pop;

  // A beat leaves when it is presented and accepted; a word lands one cycle
  // after its read strobe.
  assign w_pop  = (r_occ != 2'd0) && bus.m_ready;
  assign w_push = r_inflight;

  // Credit seen by the issue logic: stored words plus the word in flight,
  // minus a slot being vacated by a pop this same cycle.
  assign w_credit_after_pop = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

  assign w_rd_en = (r_state == BURST) && (r_issue_cnt != c_LEN_ZERO) &&
                   !bus.fifo_empty && (w_credit_after_pop < 2'd2);

  // Zero-length requests are handshaken but start nothing.
  assign w_req_take = (r_state == IDLE) && bus.req_valid && (bus.req_len != c_LEN_ZERO);
  assign w_last_pop = w_pop && (r_beat_cnt == c_LEN_ONE);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: leave BURST on the last issued read, leave FLUSH on
  // the accepted last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_take) w_state_nxt = BURST;
      BURST:   if (w_rd_en && (r_issue_cnt == c_LEN_ONE)) w_state_nxt = FLUSH;
      FLUSH:   if (w_last_pop) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Issue and beat counters, both saturating at zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
    end else if (w_req_take) begin
      r_issue_cnt <= bus.req_len;
      r_beat_cnt  <= bus.req_len;
    end else begin
      if (w_rd_en) r_issue_cnt <= r_issue_cnt - c_LEN_ONE;
      if (w_pop && (r_beat_cnt != c_LEN_ZERO)) r_beat_cnt <= r_beat_cnt - c_LEN_ONE;
    end
  end

  // Read-in-flight flag tracks the FIFO's one-cycle read latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
    end
  end

  // Two-entry skid buffer kept in arrival order; r_buf0 is always the oldest
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_occ  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= bus.fifo_read_data;
          else               r_buf1 <= bus.fifo_read_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word queues behind whatever remains.
          if (r_occ == 2'd1) begin
            r_buf0 <= bus.fifo_read_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= bus.fifo_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready        = (r_state == IDLE);
  assign bus.busy             = (r_state != IDLE);
  assign bus.fifo_read_enable = w_rd_en;
  assign bus.m_valid          = (r_occ != 2'd0);
  assign bus.m_data           = r_buf0;
  assign bus.m_last           = (r_occ != 2'd0) && (r_beat_cnt == c_LEN_ONE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Self-checking bench for fifo_stream_reader. A queue-based
//                FIFO model feeds the read port; a stream monitor records
//                every accepted beat and watches handshake/credit rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int LW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) ifc ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FIFO model: one-cycle read latency ----------------
  logic [DW-1:0] fifo_q[$];
  logic          wr_en   = 1'b0;
  logic          fl_en   = 1'b0;
  logic [DW-1:0] wr_word = '0;

  always @(posedge clk) begin
    if (ifc.fifo_read_enable === 1'b1 && fifo_q.size() > 0)
      ifc.fifo_read_data <= fifo_q.pop_front();
    if (fl_en) fifo_q.delete();
    if (wr_en) fifo_q.push_back(wr_word);
    ifc.fifo_empty <= (fifo_q.size() == 0);
  end

  // ---------------- Stream monitor (samples on falling edge) ----------------
  logic [DW-1:0] got_data[$];
  bit            got_last[$];
  int            got_cyc[$];
  int            rd_cnt = 0, pop_cnt = 0, rd_total = 0;
  int            viol_empty = 0, viol_credit = 0, viol_hold = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      rd_cnt     = 0;
      pop_cnt    = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall && (ifc.m_valid !== 1'b1 || ifc.m_data !== prev_data || ifc.m_last !== prev_last))
        viol_hold++;
      if (ifc.fifo_read_enable === 1'b1) begin
        rd_cnt++;
        rd_total++;
        if (ifc.fifo_empty !== 1'b0) viol_empty++;
      end
      if (ifc.m_valid === 1'b1 && ifc.m_ready === 1'b1) begin
        pop_cnt++;
        got_data.push_back(ifc.m_data);
        got_last.push_back(ifc.m_last === 1'b1);
        got_cyc.push_back(cyc);
      end
      // Words requested but not yet delivered can never exceed the buffer depth.
      if (rd_cnt - pop_cnt > 2) viol_credit++;
      prev_stall = (ifc.m_valid === 1'b1) && (ifc.m_ready !== 1'b1);
      prev_data  = ifc.m_data;
      prev_last  = ifc.m_last;
    end
  end

  // ---------------- Stimulus helpers ----------------
  logic [DW-1:0] to_write[$];
  int            feed_pct  = 100;
  bit            rnd_ready = 0;

  // Advance one cycle; feed the FIFO model and optionally randomise m_ready.
  task automatic tick();
    if (to_write.size() > 0 && int'($urandom_range(99, 0)) < feed_pct) begin
      wr_en   = 1'b1;
      wr_word = to_write.pop_front();
    end else begin
      wr_en = 1'b0;
    end
    if (rnd_ready) ifc.m_ready = 1'($urandom_range(1, 0));
    @(posedge clk);
    #1;
    fl_en = 1'b0;
  endtask

  task automatic send_req(input int len, output int acc);
    ifc.req_valid = 1'b1;
    ifc.req_len   = LW'(len);
    acc = cyc + 1;
    tick();
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_beats(input int base, input int n, input int budget, output bit ok);
    int k = 0;
    while (got_data.size() < base + n && k < budget) begin
      tick();
      k++;
    end
    ok = (got_data.size() >= base + n);
  endtask

  task automatic flush_fifo();
    fl_en = 1'b1;
    tick();
    tick();
  endtask

  // Reference: beat i must carry exp[i], m_last only on the final one.
  function automatic int count_mismatch(input int base, input logic [DW-1:0] exp[$]);
    int mm = 0;
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i >= got_data.size()) mm++;
      else if (got_data[base+i] !== exp[i] || got_last[base+i] != (i == exp.size() - 1)) mm++;
    end
    return mm;
  endfunction

  // ---------------- Tests ----------------
  task automatic test_reset();
    ifc.req_valid = 1'b0;
    ifc.req_len   = '0;
    ifc.m_ready   = 1'b0;
    rstn = 1'b0;
    repeat (3) tick();
    checks++; if (ifc.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b want=1", ifc.req_ready); end
    checks++; if (ifc.fifo_read_enable !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b want=0", ifc.fifo_read_enable); end
    checks++; if (ifc.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b want=0", ifc.m_valid); end
    checks++; if (ifc.m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h want=00", ifc.m_data); end
    checks++; if (ifc.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b want=0", ifc.m_last); end
    checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", ifc.busy); end
    rstn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp[$];
    int base, acc, rd0;
    bit ok, consec;
    exp = '{8'h11, 8'h22, 8'h33};
    to_write = exp;
    feed_pct = 100;
    ifc.m_ready = 1'b1;
    repeat (6) tick();
    base = got_data.size();
    rd0  = rd_total;
    send_req(3, acc);
    wait_beats(base, 3, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout beats=%0d want=3", got_data.size() - base); end
    checks++; if (count_mismatch(base, exp) != 0) begin failures++; $display("FAIL basic_order mismatches=%0d want=0", count_mismatch(base, exp)); end
    if (ok) begin
      checks++;
      if (got_cyc[base] != acc + 2) begin failures++; $display("FAIL basic_latency first_beat_cycle=%0d want=%0d", got_cyc[base], acc + 2); end
      consec = (got_cyc[base+1] == got_cyc[base] + 1) && (got_cyc[base+2] == got_cyc[base] + 2);
      checks++;
      if (!consec) begin failures++; $display("FAIL basic_throughput cycles=%0d,%0d,%0d want consecutive", got_cyc[base], got_cyc[base+1], got_cyc[base+2]); end
    end
    checks++; if (ifc.req_ready !== 1'b1 || ifc.busy !== 1'b0) begin failures++; $display("FAIL basic_idle req_ready=%b busy=%b want 1/0", ifc.req_ready, ifc.busy); end
    repeat (4) tick();
    checks++; if (got_data.size() != base + 3 || rd_total - rd0 != 3) begin failures++; $display("FAIL basic_counts beats=%0d reads=%0d want 3/3", got_data.size() - base, rd_total - rd0); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp[$];
    int base, acc, rd0, k, bad;
    bit ok;
    for (int i = 0; i < 4; i++) exp.push_back(DW'($urandom));
    to_write = exp;
    ifc.m_ready = 1'b0;
    repeat (7) tick();
    base = got_data.size();
    rd0  = rd_total;
    send_req(4, acc);
    k = 0;
    while (ifc.m_valid !== 1'b1 && k < 10) begin tick(); k++; end
    checks++; if (ifc.m_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%b want=1", ifc.m_valid); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifc.m_valid !== 1'b1 || ifc.m_data !== exp[0] || ifc.m_last !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d want=0 data=%h want=%h", bad, ifc.m_data, exp[0]); end
    checks++; if (rd_total - rd0 != 2) begin failures++; $display("FAIL bp_reads_ahead reads=%0d want=2", rd_total - rd0); end
    ifc.m_ready = 1'b1;
    wait_beats(base, 4, 30, ok);
    checks++; if (!ok || count_mismatch(base, exp) != 0) begin failures++; $display("FAIL bp_order beats=%0d mismatches=%0d want 4/0", got_data.size() - base, count_mismatch(base, exp)); end
    repeat (4) tick();
    checks++; if (got_data.size() != base + 4 || ifc.busy !== 1'b0) begin failures++; $display("FAIL bp_done beats=%0d busy=%b want 4/0", got_data.size() - base, ifc.busy); end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] exp[$];
    int base, acc, ve0, busy_bad, early;
    bit ok;
    for (int i = 0; i < 4; i++) exp.push_back(DW'($urandom));
    to_write.push_back(exp[0]);
    to_write.push_back(exp[1]);
    ifc.m_ready = 1'b1;
    repeat (5) tick();
    base = got_data.size();
    ve0  = viol_empty;
    send_req(4, acc);
    busy_bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ifc.busy !== 1'b1) busy_bad++;
    end
    early = got_data.size() - base;
    to_write.push_back(exp[2]);
    to_write.push_back(exp[3]);
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL uf_busy idle_cycles=%0d want=0", busy_bad); end
    checks++; if (early != 2) begin failures++; $display("FAIL uf_partial beats=%0d want=2", early); end
    wait_beats(base, 4, 30, ok);
    checks++; if (!ok || count_mismatch(base, exp) != 0) begin failures++; $display("FAIL uf_order beats=%0d mismatches=%0d want 4/0", got_data.size() - base, count_mismatch(base, exp)); end
    checks++; if (viol_empty != ve0) begin failures++; $display("FAIL uf_read_while_empty count=%0d want=0", viol_empty - ve0); end
    repeat (3) tick();
  endtask

  task automatic test_zero_len();
    int base, rd0, acc, bad;
    for (int i = 0; i < 3; i++) to_write.push_back(DW'($urandom));
    ifc.m_ready = 1'b1;
    repeat (5) tick();
    base = got_data.size();
    rd0  = rd_total;
    send_req(0, acc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.req_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.fifo_read_enable !== 1'b0 || ifc.m_valid !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL zero_len_idle bad_cycles=%0d want=0", bad); end
    checks++; if (rd_total != rd0 || got_data.size() != base) begin failures++; $display("FAIL zero_len_activity reads=%0d beats=%0d want 0/0", rd_total - rd0, got_data.size() - base); end
    flush_fifo();
  endtask

  task automatic test_reset_midburst();
    logic [DW-1:0] exp[$];
    int base, acc, k;
    for (int i = 0; i < 6; i++) exp.push_back(DW'($urandom));
    to_write = exp;
    ifc.m_ready = 1'b1;
    repeat (8) tick();
    base = got_data.size();
    send_req(6, acc);
    k = 0;
    while (got_data.size() < base + 2 && k < 20) begin tick(); k++; end
    rstn = 1'b0;
    #1;
    checks++;
    if (ifc.req_ready !== 1'b1 || ifc.fifo_read_enable !== 1'b0 || ifc.m_valid !== 1'b0 ||
        ifc.m_data !== 8'h00 || ifc.m_last !== 1'b0 || ifc.busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs rdy=%b rd=%b vld=%b data=%h last=%b busy=%b want 1/0/0/00/0/0",
               ifc.req_ready, ifc.fifo_read_enable, ifc.m_valid, ifc.m_data, ifc.m_last, ifc.busy);
    end
    repeat (2) tick();
    rstn = 1'b1;
    repeat (20) tick();
    checks++; if (got_data.size() != base + 2) begin failures++; $display("FAIL midreset_no_beats beats=%0d want=2", got_data.size() - base); end
    checks++;
    if (got_data.size() < base + 2 || got_data[base] !== exp[0] || got_data[base+1] !== exp[1]) begin
      failures++; $display("FAIL midreset_prefix beats=%0d want first two words %h %h", got_data.size() - base, exp[0], exp[1]);
    end
    flush_fifo();
  endtask

  task automatic test_max_len();
    logic [DW-1:0] exp[$];
    int base, acc, rd0;
    bit ok, consec;
    for (int i = 0; i < 255; i++) exp.push_back(DW'($urandom));
    to_write = exp;
    feed_pct = 100;
    ifc.m_ready = 1'b1;
    repeat (260) tick();
    base = got_data.size();
    rd0  = rd_total;
    send_req(255, acc);
    wait_beats(base, 255, 400, ok);
    checks++; if (!ok || count_mismatch(base, exp) != 0) begin failures++; $display("FAIL maxlen_order beats=%0d mismatches=%0d want 255/0", got_data.size() - base, count_mismatch(base, exp)); end
    if (ok) begin
      consec = 1;
      for (int i = 1; i < 255; i++) if (got_cyc[base+i] != got_cyc[base] + i) consec = 0;
      checks++; if (!consec) begin failures++; $display("FAIL maxlen_throughput span=%0d want=254", got_cyc[base+254] - got_cyc[base]); end
    end
    repeat (3) tick();
    checks++; if (rd_total - rd0 != 255 || ifc.req_ready !== 1'b1) begin failures++; $display("FAIL maxlen_done reads=%0d req_ready=%b want 255/1", rd_total - rd0, ifc.req_ready); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp[$];
    int base, acc, lasts, ve0, vc0, vh0;
    bit ok;
    for (int i = 0; i < 200; i++) exp.push_back(DW'($urandom));
    to_write = exp;
    feed_pct  = 60;
    rnd_ready = 1;
    base = got_data.size();
    ve0 = viol_empty; vc0 = viol_credit; vh0 = viol_hold;
    send_req(200, acc);
    wait_beats(base, 200, 3000, ok);
    rnd_ready = 0;
    ifc.m_ready = 1'b1;
    feed_pct = 100;
    repeat (5) tick();
    lasts = 0;
    for (int i = base; i < got_data.size(); i++) if (got_last[i]) lasts++;
    checks++; if (!ok || count_mismatch(base, exp) != 0) begin failures++; $display("FAIL random_order beats=%0d mismatches=%0d want 200/0", got_data.size() - base, count_mismatch(base, exp)); end
    checks++; if (lasts != 1 || got_data.size() != base + 200) begin failures++; $display("FAIL random_last lasts=%0d beats=%0d want 1/200", lasts, got_data.size() - base); end
    checks++; if (viol_empty != ve0) begin failures++; $display("FAIL random_read_while_empty count=%0d want=0", viol_empty - ve0); end
    checks++; if (viol_credit != vc0) begin failures++; $display("FAIL random_credit count=%0d want=0", viol_credit - vc0); end
    checks++; if (viol_hold != vh0) begin failures++; $display("FAIL random_hold count=%0d want=0", viol_hold - vh0); end
  endtask

  task automatic test_global_rules();
    checks++; if (viol_empty != 0) begin failures++; $display("FAIL rule_read_while_empty count=%0d want=0", viol_empty); end
    checks++; if (viol_credit != 0) begin failures++; $display("FAIL rule_credit count=%0d want=0", viol_credit); end
    checks++; if (viol_hold != 0) begin failures++; $display("FAIL rule_hold_stable count=%0d want=0", viol_hold); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_zero_len();
    test_reset_midburst();
    test_max_len();
    test_random();
    test_global_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t limit=500000", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
